// File: rtl/gray_code_counter.sv
// Up/down counter that keeps a registered binary count together with its
// registered Gray-coded copy. It supports binary or Gray loads and either wrap or saturate behaviour.
module gray_code_counter #(
    parameter int WIDTH     = 8,
    parameter int WRAP      = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap_pulse
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("gray_code_counter: WIDTH must be at least 2");
        end
        if (RESET_VAL < 0 || (WIDTH < 31 && RESET_VAL >= (1 << WIDTH))) begin : g_bad_reset
            $error("gray_code_counter: RESET_VAL does not fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RESET_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             at_max_reg;
    logic             at_min_reg;
    logic             wrap_reg;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_next;
    logic             wrap_next;

    // Each binary bit is the XOR of all Gray bits at and above it; written as a
    // reduction so no bit depends on another bit of the same vector.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
            assign load_bin[gi] = ^load_val[WIDTH-1:gi];
        end
    endgenerate

    always_comb begin
        bin_next  = bin_reg;
        wrap_next = 1'b0;
        if (load) begin
            bin_next = load_is_gray ? load_bin : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (&bin_reg) begin
                    wrap_next = 1'b1;
                    bin_next  = (WRAP != 0) ? '0 : bin_reg;
                end else begin
                    bin_next = bin_reg + WIDTH'(1);
                end
            end else begin
                if (~|bin_reg) begin
                    wrap_next = 1'b1;
                    bin_next  = (WRAP != 0) ? '1 : bin_reg;
                end else begin
                    bin_next = bin_reg - WIDTH'(1);
                end
            end
        end
    end

    // Flags and Gray code are derived from the next value so every output is
    // a flop and changes in the same cycle as bin_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg    <= RESET_BIN;
            gray_reg   <= RESET_GRAY;
            at_max_reg <= &RESET_BIN;
            at_min_reg <= ~|RESET_BIN;
            wrap_reg   <= 1'b0;
        end else begin
            bin_reg    <= bin_next;
            gray_reg   <= bin_next ^ (bin_next >> 1);
            at_max_reg <= &bin_next;
            at_min_reg <= ~|bin_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign bin_out    = bin_reg;
    assign gray_out   = gray_reg;
    assign at_max     = at_max_reg;
    assign at_min     = at_min_reg;
    assign wrap_pulse = wrap_reg;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: an 8-bit wrapping instance with
// RESET_VAL=5 and a 4-bit saturating instance, checked against hand-computed values.
module tb_gray_code_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit wrapping instance
    logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b1, load8 = 1'b0, lg8 = 1'b0;
    logic [7:0] lv8 = 8'h00;
    logic [7:0] bin8, gray8;
    logic       max8, min8, wrap8;

    // 4-bit saturating instance
    logic       rst4 = 1'b1, en4 = 1'b0, up4 = 1'b1, load4 = 1'b0, lg4 = 1'b0;
    logic [3:0] lv4 = 4'h0;
    logic [3:0] bin4, gray4;
    logic       max4, min4, wrap4;

    int tests_run    = 0;
    int tests_failed = 0;

    gray_code_counter #(.WIDTH(8), .WRAP(1), .RESET_VAL(8'h05)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .load(load8),
        .load_is_gray(lg8), .load_val(lv8), .bin_out(bin8), .gray_out(gray8),
        .at_max(max8), .at_min(min8), .wrap_pulse(wrap8)
    );

    gray_code_counter #(.WIDTH(4), .WRAP(0), .RESET_VAL(0)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .up_dn(up4), .load(load4),
        .load_is_gray(lg4), .load_val(lv4), .bin_out(bin4), .gray_out(gray4),
        .at_max(max4), .at_min(min4), .wrap_pulse(wrap4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the full 8-bit output set against expected values
    task automatic expect8(input string name, input logic [7:0] eb, input logic [7:0] eg,
                           input logic emax, input logic emin, input logic ewrap);
        tests_run++;
        $display("[TB] %s: bin=%02h gray=%02h max=%0b min=%0b wrap=%0b",
                 name, bin8, gray8, max8, min8, wrap8);
        if ({bin8, gray8, max8, min8, wrap8} !== {eb, eg, emax, emin, ewrap}) begin
            tests_failed++;
            $display("FAIL %s: got bin=%02h gray=%02h max=%0b min=%0b wrap=%0b, expected bin=%02h gray=%02h max=%0b min=%0b wrap=%0b",
                     name, bin8, gray8, max8, min8, wrap8, eb, eg, emax, emin, ewrap);
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst4 = 1'b1;
        tick();
        rst8 = 1'b0; rst4 = 1'b0;
        expect8("reset8", 8'h05, 8'h07, 1'b0, 1'b0, 1'b0);
        tests_run++;
        $display("[TB] reset4: bin=%h gray=%h min=%0b max=%0b wrap=%0b", bin4, gray4, min4, max4, wrap4);
        if ({bin4, gray4, max4, min4, wrap4} !== {4'h0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset4: got bin=%h gray=%h max=%0b min=%0b wrap=%0b, expected 0 0 0 1 0",
                     bin4, gray4, max4, min4, wrap4);
        end
    endtask

    task automatic test_wrap_up();
        load8 = 1'b1; lg8 = 1'b0; lv8 = 8'hFE;
        tick();
        load8 = 1'b0;
        expect8("load_fe", 8'hFE, 8'h81, 1'b0, 1'b0, 1'b0);
        en8 = 1'b1; up8 = 1'b1;
        tick(); expect8("up_ff", 8'hFF, 8'h80, 1'b1, 1'b0, 1'b0);
        tick(); expect8("up_wrap_00", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        tick(); expect8("up_01", 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        en8 = 1'b0;
    endtask

    task automatic test_wrap_down();
        load8 = 1'b1; lg8 = 1'b0; lv8 = 8'h00;
        tick();
        load8 = 1'b0;
        expect8("load_00", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        en8 = 1'b1; up8 = 1'b0;
        tick(); expect8("down_wrap_ff", 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
        tick(); expect8("down_fe", 8'hFE, 8'h81, 1'b0, 1'b0, 1'b0);
        en8 = 1'b0;
    endtask

    task automatic test_hold_and_load_clears_wrap();
        load8 = 1'b1; lg8 = 1'b0; lv8 = 8'hFF;
        tick();
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        tick(); expect8("wrap_before_hold", 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
        en8 = 1'b0;
        tick(); expect8("hold_1", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        tick(); expect8("hold_2", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        en8 = 1'b1; up8 = 1'b0;
        tick(); expect8("wrap_before_load", 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1);
        en8 = 1'b0; load8 = 1'b1; lv8 = 8'h10;
        tick(); expect8("load_after_wrap", 8'h10, 8'h18, 1'b0, 1'b0, 1'b0);
        load8 = 1'b0;
    endtask

    task automatic test_load_gray();
        load8 = 1'b1; lg8 = 1'b1; lv8 = 8'hC0; en8 = 1'b1; up8 = 1'b1;
        tick(); expect8("load_gray_c0", 8'h80, 8'hC0, 1'b0, 1'b0, 1'b0);
        lv8 = 8'h5A;
        tick(); expect8("load_gray_5a", 8'h6C, 8'h5A, 1'b0, 1'b0, 1'b0);
        lg8 = 1'b0; lv8 = 8'hC0;
        tick(); expect8("load_bin_c0", 8'hC0, 8'hA0, 1'b0, 1'b0, 1'b0);
        load8 = 1'b0;
        tick(); expect8("count_after_load", 8'hC1, 8'hA1, 1'b0, 1'b0, 1'b0);
        en8 = 1'b0;
    endtask

    // 512 steps, flipping direction every 37 cycles with no idle cycle
    task automatic test_free_run();
        logic [7:0] exp_bin, exp_gray, prev_gray;
        logic       exp_wrap, dir;
        int         errs;
        errs = 0;
        load8 = 1'b1; lg8 = 1'b0; lv8 = 8'hF0;
        tick();
        load8 = 1'b0; en8 = 1'b1;
        exp_bin   = 8'hF0;
        prev_gray = 8'hF0 ^ 8'h78;
        for (int i = 0; i < 512; i++) begin
            dir = ((i / 37) % 2) == 0;
            up8 = dir;
            exp_wrap = dir ? (exp_bin == 8'hFF) : (exp_bin == 8'h00);
            exp_bin  = dir ? exp_bin + 8'd1 : exp_bin - 8'd1;
            exp_gray = exp_bin ^ (exp_bin >> 1);
            tick();
            tests_run++;
            if (bin8 !== exp_bin || gray8 !== exp_gray || wrap8 !== exp_wrap ||
                $countones(gray8 ^ prev_gray) != 1) begin
                tests_failed++;
                errs++;
                if (errs <= 5)
                    $display("FAIL free_run step %0d: got bin=%02h gray=%02h wrap=%0b, expected bin=%02h gray=%02h wrap=%0b (one-bit change from %02h)",
                             i, bin8, gray8, wrap8, exp_bin, exp_gray, exp_wrap, prev_gray);
            end
            prev_gray = exp_gray;
        end
        $display("[TB] free_run: 512 steps, final bin=%02h", bin8);
        en8 = 1'b0;
    endtask

    task automatic test_saturate();
        logic [3:0] eb;
        logic       ew;
        en4 = 1'b1; up4 = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            eb = (k >= 15) ? 4'hF : 4'(k);
            ew = (k >= 16);
            tick();
            tests_run++;
            $display("[TB] sat_up %0d: bin=%h gray=%h max=%0b wrap=%0b", k, bin4, gray4, max4, wrap4);
            if (bin4 !== eb || wrap4 !== ew || (k >= 15 && (gray4 !== 4'h8 || max4 !== 1'b1))) begin
                tests_failed++;
                $display("FAIL sat_up %0d: got bin=%h gray=%h max=%0b wrap=%0b, expected bin=%h wrap=%0b",
                         k, bin4, gray4, max4, wrap4, eb, ew);
            end
        end
        up4 = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            eb = (k >= 15) ? 4'h0 : 4'(15 - k);
            ew = (k >= 16);
            tick();
            tests_run++;
            $display("[TB] sat_dn %0d: bin=%h gray=%h min=%0b wrap=%0b", k, bin4, gray4, min4, wrap4);
            if (bin4 !== eb || wrap4 !== ew || (k >= 15 && (gray4 !== 4'h0 || min4 !== 1'b1))) begin
                tests_failed++;
                $display("FAIL sat_dn %0d: got bin=%h gray=%h min=%0b wrap=%0b, expected bin=%h wrap=%0b",
                         k, bin4, gray4, min4, wrap4, eb, ew);
            end
        end
        en4 = 1'b0;
        tick();
        tests_run++;
        if (wrap4 !== 1'b0 || bin4 !== 4'h0) begin
            tests_failed++;
            $display("FAIL sat_hold: got bin=%h wrap=%0b, expected bin=0 wrap=0", bin4, wrap4);
        end
    endtask

    task automatic test_mid_reset();
        load8 = 1'b1; lg8 = 1'b0; lv8 = 8'h30;
        tick();
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        expect8("run_to_37", 8'h37, 8'h2C, 1'b0, 1'b0, 1'b0);
        rst8 = 1'b1; load8 = 1'b1; lv8 = 8'hAA;
        tick(); expect8("reset_over_load", 8'h05, 8'h07, 1'b0, 1'b0, 1'b0);
        rst8 = 1'b0; load8 = 1'b0;
        tick(); expect8("resume_06", 8'h06, 8'h05, 1'b0, 1'b0, 1'b0);
        en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_hold_and_load_clears_wrap();
        test_load_gray();
        test_free_run();
        test_saturate();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
